// File: rtl/axi2apb_pkg.sv
// axi2apb_pkg: FSM state encoding, AXI response codes and log2 helper for the AXI-to-APB bridge
package axi2apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WD,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int log2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/axi2apb_apb_ctrl_if.sv
// axi2apb_apb_ctrl_if: APB bus between the bridge sequencer (master) and an APB slave
interface axi2apb_apb_ctrl_if #(
    parameter int APB_ADDR_WIDTH = 12
);

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic                      pready;
    logic                      pslverr;

    modport master (output psel, penable, pwrite, paddr, input pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, output pready, pslverr);

endinterface

// File: rtl/axi2apb_timeout_cnt.sv
// axi2apb_timeout_cnt: ACCESS-phase watchdog, flags the last allowed wait cycle (built only with APB_TIMEOUT_EN)
module axi2apb_timeout_cnt
    import axi2apb_pkg::*;
#(
    parameter int APB_TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = log2(APB_TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // count ACCESS cycles, restart at every SETUP
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;

    // counter register
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign expired = en && (cnt_q == CNT_W'(APB_TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi2apb_apb_ctrl.sv
// axi2apb_apb_ctrl: APB master sequencer, one APB transfer per queued command; optional ACCESS timeout via APB_TIMEOUT_EN
module axi2apb_apb_ctrl
    import axi2apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH     = 12,
    parameter int APB_TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cmd_valid,
    input  logic                      cmd_read,
    input  logic [APB_ADDR_WIDTH+3:0] cmd_addr,
    output logic                      cmd_pop,
    input  logic                      wdata_valid,
    input  logic                      finish_rd,
    input  logic                      finish_wr,
    axi2apb_apb_ctrl_if.master        apb,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      busy
);

    apb_state_e                state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel, penable, finish, expired;
    logic                      unused_ok;

    assign unused_ok = ^cmd_addr[APB_ADDR_WIDTH+3:APB_ADDR_WIDTH];

`ifdef APB_TIMEOUT_EN
    axi2apb_timeout_cnt #(
        .APB_TIMEOUT_CYCLES(APB_TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (state_q == SETUP),
        .en      (state_q == ACCESS),
        .expired (expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg = (APB_TIMEOUT_CYCLES > 0);
    assign expired    = 1'b0;
`endif

    // only the finish of the latched command's direction can retire it
    assign finish = pwrite_q ? finish_wr : finish_rd;

    // state and latched command
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
        end

    // next state; the command is captured only in IDLE so it stays stable for the whole transfer
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        case (state_q)
            IDLE:
                if (cmd_valid) begin
                    paddr_d  = cmd_addr[APB_ADDR_WIDTH-1:0];
                    pwrite_d = ~cmd_read;
                    state_d  = (cmd_read || wdata_valid) ? SETUP : WAIT_WD;
                end
            WAIT_WD: state_d = wdata_valid ? SETUP : WAIT_WD;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = pready_o ? RESP : ACCESS;
            RESP:    state_d = finish ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // APB control and qualified handshake, all decoded from the state
    always_comb begin
        psel      = (state_q == SETUP) || (state_q == ACCESS);
        penable   = (state_q == ACCESS);
        busy      = (state_q != IDLE);
        cmd_pop   = (state_q == RESP) && finish;
        pready_o  = (apb.pready && psel && penable) || expired;
        pslverr_o = (apb.pslverr && pready_o) || expired;
    end

    assign apb.psel    = psel;
    assign apb.penable = penable;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;

endmodule

// File: tb/tb_axi2apb_apb_ctrl.sv
// tb_axi2apb_apb_ctrl: scoreboard bench for the APB sequencer with a reactive slave/response-stage model
module tb_axi2apb_apb_ctrl;

    localparam int AW = 12;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_read = 1'b0;
    logic [AW+3:0] cmd_addr = '0;
    logic          wdata_valid = 1'b0, finish_rd = 1'b0, finish_wr = 1'b0;
    logic          cmd_pop, pready_o, pslverr_o, busy;

    always #5 clk = ~clk;

    axi2apb_apb_ctrl_if #(.APB_ADDR_WIDTH(AW)) apb ();

    axi2apb_apb_ctrl #(
        .APB_ADDR_WIDTH     (AW),
        .APB_TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_read    (cmd_read),
        .cmd_addr    (cmd_addr),
        .cmd_pop     (cmd_pop),
        .wdata_valid (wdata_valid),
        .finish_rd   (finish_rd),
        .finish_wr   (finish_wr),
        .apb         (apb),
        .pready_o    (pready_o),
        .pslverr_o   (pslverr_o),
        .busy        (busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0, n_pop = 0, exp_pop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // every completed APB transfer is matched against the oldest expected command
    always @(negedge clk) begin
        exp_t e;
        if (cmd_pop === 1'b1) n_pop++;
        if (pready_o === 1'b1) begin
            if (sb.size() == 0) check("sb_unexpected_xfer", 1, 0);
            else begin
                e = sb.pop_front();
                check("sb_paddr", apb.paddr, e.addr);
                check("sb_pwrite", apb.pwrite, e.wr);
                check("sb_pslverr_o", pslverr_o, e.err);
            end
        end
    end

    task automatic idle_inputs();
        cmd_valid   = 1'b0;
        wdata_valid = 1'b0;
        finish_rd   = 1'b0;
        finish_wr   = 1'b0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
    endtask

    // one command: wd = wdata delay, rdy = pready-low ACCESS cycles, rdel = finish delay in RESP,
    // noise = hold the wrong-direction finish (and the right one before RESP), drop = cmd_valid only in cycle 0
    task automatic run_cmd(input logic rd, input logic [AW+3:0] addr, input int wd, input int rdy,
                           input logic err, input int rdel, input bit noise, input bit drop);
        int   c = 0, setups = 0, acc = 0, waits = 0, errs = 0, pop_c = -1, j = 0, badaddr = 0;
        bit   in_resp = 0, seen_setup = 0, nxt_pready;
        logic corr;
        int   exp_acc;
        logic exp_err;
        exp_acc = rdy + 1;
        exp_err = err;
`ifdef APB_TIMEOUT_EN
        if (rdy >= TO) begin
            exp_acc = TO;
            exp_err = 1'b1;
        end
`endif
        sb.push_back('{addr[AW-1:0], ~rd, exp_err});
        cmd_valid   = 1'b1;
        cmd_read    = rd;
        cmd_addr    = addr;
        wdata_valid = (wd == 0);
        apb.pready  = 1'b0;
        apb.pslverr = err;
        finish_rd   = noise;
        finish_wr   = noise;
        while (pop_c < 0 && c < 400) begin
            @(negedge clk);
            if (cmd_pop) pop_c = c;
            if (apb.psel && !apb.penable) begin
                setups++;
                seen_setup = 1;
            end
            if (apb.psel && apb.penable) acc++;
            if (apb.psel && apb.paddr !== addr[AW-1:0]) badaddr++;
            if (pslverr_o) errs++;
            if (busy && !apb.psel && !seen_setup) waits++;
            nxt_pready = apb.psel && !pready_o && ((apb.penable ? acc : 0) >= rdy);
            if (pready_o) begin
                in_resp = 1;
                j = 0;
            end else if (in_resp) j++;
            @(posedge clk);
            #1;
            c++;
            if (pop_c >= 0) idle_inputs();
            else begin
                apb.pready  = nxt_pready;
                cmd_valid   = !drop;
                wdata_valid = (c >= wd);
                corr        = in_resp ? (j >= rdel) : noise;
                finish_rd   = rd ? corr : noise;
                finish_wr   = rd ? noise : corr;
            end
        end
        if (pop_c < 0) begin
            check("pop_within_bound", 0, 1);
            idle_inputs();
        end
        exp_pop++;
        check("setup_cycles", setups, 1);
        check("access_cycles", acc, exp_acc);
        check("wait_wd_cycles", waits, rd ? 0 : wd);
        check("pslverr_o_cycles", errs, {31'd0, exp_err});
        check("pop_latency", pop_c, 2 + (rd ? 0 : wd) + exp_acc + rdel);
        check("paddr_stable", badaddr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, n_chk %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int p0, k;
        idle_inputs();
        #1;
        check("rst_psel", apb.psel, 0);
        check("rst_penable", apb.penable, 0);
        check("rst_pwrite", apb.pwrite, 0);
        check("rst_paddr", apb.paddr, 0);
        check("rst_cmd_pop", cmd_pop, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_cmd(1, 16'h0124, 0, 0, 0, 0, 0, 0);
        run_cmd(0, 16'h0008, 5, 0, 0, 0, 1, 0);
        run_cmd(1, 16'h03f0, 0, 10, 1, 2, 1, 0);
        p0 = n_pop;
        run_cmd(1, 16'h0a00, 0, 0, 0, 4, 0, 0);
        run_cmd(1, 16'h5004, 0, 0, 0, 0, 0, 0);
        check("b2b_pops", n_pop - p0, 2);
        run_cmd(0, 16'h27fc, 2, 1, 0, 1, 1, 1);
`ifdef APB_TIMEOUT_EN
        run_cmd(1, 16'h0100, 0, 1000, 0, 0, 0, 0);
`endif
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 16'h00c8;
        k = 0;
        while (!(apb.psel && apb.penable) && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reach_access", apb.psel && apb.penable, 1);
        p0 = n_pop;
        rstn = 1'b0;
        #1;
        check("rst_mid_psel", apb.psel, 0);
        check("rst_mid_penable", apb.penable, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_pop", cmd_pop, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("rst_mid_no_pop", n_pop - p0, 0);
        run_cmd(1, 16'h00c8, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            run_cmd(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        repeat (3) @(posedge clk);
        #1;
        check("total_pops", n_pop, exp_pop);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
